mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read data memory between two requesters:
  - port 0: the risc_v core.
  - port 1: a secondary master (DMA/loader).
- Issues at most one access per cycle.
- Grants port 0 by priority, bounded by a fairness counter so port 1 cannot starve.
- Routes read data back to the requester that issued the read.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, max consecutive port-0 grants while port 1 waits (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- p0_req  in  1  port 0 request; held with attributes until p0_gnt.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_funct3  in  3  port 0 access size/sign (RISC-V funct3 encoding).
- p0_gnt  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_funct3, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_ra  out  ADDR_W  memory read address.
- mem_wa  out  ADDR_W  memory write address.
- mem_wd  out  DATA_W  memory write data.
- mem_wen  out  1  memory write enable.
- mem_funct3  out  3  memory access funct3.
- mem_rd  in  DATA_W  memory read data, valid one cycle after mem_ra presented.

Behaviour:
- Clock/reset: single clock clk. rst is asynchronous, active-high. Registered state clears immediately on rst assertion.
- Reset values:
  - burst_cnt=0, last_gnt=0.
  - rd_pend=0, rd_port=0.
  - p0_rvalid=p1_rvalid=0.
  - While rst is high, gnt outputs=0 and mem_wen=0.
- Arbitration (combinational, same cycle as req):
  - Only p0_req: grant 0.
  - Only p1_req: grant 1.
  - Both: grant 1 if burst_cnt==MAX_BURST, else grant 0.
  - Neither: no grant.
  - Exactly one gnt high per cycle at most.
- burst_cnt update (registered):
  - Port 0 granted while p1_req high: burst_cnt+1, saturating at MAX_BURST.
  - Port 1 granted: burst_cnt=0.
  - No p1_req: burst_cnt=0.
- Granted access drives memory in the same cycle:
  - mem_ra=addr, mem_wa=addr, mem_funct3=funct3.
  - mem_wd=wdata, mem_wen=we.
- Idle cycle:
  - mem_wen=0, mem_funct3=3'b010.
  - mem_ra and mem_wa hold the last granted address (registered copy).
- Read return:
  - A granted read sets rd_pend=1 and rd_port=winner for the next cycle.
  - Next cycle, p<rd_port>_rvalid=1 and p<rd_port>_rdata=mem_rd.
  - Latency is exactly 1 cycle after gnt.
  - The other port's rvalid stays 0; its rdata is don't-care and is driven 0.
- Back-to-back: a new grant is allowed every cycle, including read-after-read from different ports. rvalid for read N coincides with gnt for read N+1.
- Writes never assert rvalid.
- Requester rules:
  - Must hold req and attributes stable until gnt.
  - May deassert req in the gnt cycle or keep it high for a back-to-back access.
- Reset mid-operation: a pending read is discarded, and no rvalid is asserted after rst deasserts.
- last_gnt records the most recent winner; it is used only for the idle-address hold mux.

Test Plan:
- Reset:
  - Stimulus: rst=1 mid-read (p0 read granted the previous cycle).
  - Response: p0_rvalid=0 immediately; gnts=0, mem_wen=0 during rst; no rvalid after release.
- Single read:
  - Stimulus: p0 read addr 0x100; memory returns 0xDEADBEEF.
  - Response: p0_gnt=1 in cycle t with mem_ra=0x100; p0_rvalid=1, p0_rdata=0xDEADBEEF at t+1; p1_rvalid=0.
- Write:
  - Stimulus: p1 write addr 0x20, data 0x12345678, funct3=3'b000.
  - Response: same cycle p1_gnt=1, mem_wen=1, mem_wa=0x20, mem_wd=0x12345678, mem_funct3=3'b000; no rvalid.
- Fairness:
  - Stimulus: p0_req and p1_req held high continuously, MAX_BURST=4.
  - Response: grant sequence 0,0,0,0,1,0,0,0,0,1…
- Back-to-back cross-port reads:
  - Stimulus: p1 read 0x40 at t, p0 read 0x44 at t+1 (p1 idle).
  - Response: p1_rvalid at t+1 with mem_rd, p0_rvalid at t+2; no cross-routing.
- Idle:
  - Stimulus: no requests after a read to 0x80.
  - Response: mem_wen=0, mem_funct3=3'b010, mem_ra held at 0x80, burst_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system (requesters plus memory) seen from outside the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Port 0: risc_v core
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [2:0]        p0_funct3;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    // Port 1: secondary master (DMA/loader)
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [2:0]        p1_funct3;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    // Single-port synchronous-read data memory
    logic [ADDR_W-1:0] mem_ra;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_wen;
    logic [2:0]        mem_funct3;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_ra, mem_wa, mem_wd, mem_wen, mem_funct3,
        input  mem_rd
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_ra, mem_wa, mem_wd, mem_wen, mem_funct3,
        output mem_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one single-port, synchronous-read data memory.
// Port 0 (core) wins by priority, but after MAX_BURST consecutive port-0 wins
// while port 1 waits, port 1 is granted once. Grants are combinational in the
// request cycle; read data returns one cycle later to the port that issued it.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    logic [3:0]        burst_cnt;
    logic [3:0]        burst_cnt_nxt;
    port_e             last_gnt;
    port_e             rd_port;
    logic              rd_pend;
    logic [ADDR_W-1:0] p0_last_addr;
    logic [ADDR_W-1:0] p1_last_addr;
    logic              gnt0;
    logic              gnt1;

    // Fixed priority to port 0, overridden once the fairness counter saturates.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.p0_req && bus.p1_req) begin
                if (burst_cnt == BURST_LIMIT) gnt1 = 1'b1;
                else                          gnt0 = 1'b1;
            end else begin
                gnt0 = bus.p0_req;
                gnt1 = bus.p1_req;
            end
        end
    end

    assign bus.p0_gnt = gnt0;
    assign bus.p1_gnt = gnt1;

    // Steer the winner onto the memory; when idle, park the address on the last winner's.
    always_comb begin
        bus.mem_ra     = (last_gnt == PORT1) ? p1_last_addr : p0_last_addr;
        bus.mem_wa     = (last_gnt == PORT1) ? p1_last_addr : p0_last_addr;
        bus.mem_wd     = '0;
        bus.mem_wen    = 1'b0;
        bus.mem_funct3 = FUNCT3_WORD;
        if (gnt0) begin
            bus.mem_ra     = bus.p0_addr;
            bus.mem_wa     = bus.p0_addr;
            bus.mem_wd     = bus.p0_wdata;
            bus.mem_wen    = bus.p0_we;
            bus.mem_funct3 = bus.p0_funct3;
        end else if (gnt1) begin
            bus.mem_ra     = bus.p1_addr;
            bus.mem_wa     = bus.p1_addr;
            bus.mem_wd     = bus.p1_wdata;
            bus.mem_wen    = bus.p1_we;
            bus.mem_funct3 = bus.p1_funct3;
        end
    end

    // Count port-0 wins while port 1 is waiting; clear when port 1 wins or stops asking.
    always_comb begin
        burst_cnt_nxt = burst_cnt;
        if (!bus.p1_req || gnt1) begin
            burst_cnt_nxt = '0;
        end else if (gnt0 && (burst_cnt != BURST_LIMIT)) begin
            burst_cnt_nxt = burst_cnt + 4'd1;
        end
    end

    // Fairness counter, read-return tracking and the parked idle addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt    <= '0;
            last_gnt     <= PORT0;
            rd_pend      <= 1'b0;
            rd_port      <= PORT0;
            p0_last_addr <= '0;
            p1_last_addr <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            burst_cnt <= burst_cnt_nxt;
            rd_pend   <= (gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we);
            if (gnt0) begin
                rd_port      <= PORT0;
                last_gnt     <= PORT0;
                p0_last_addr <= bus.p0_addr;
            end else if (gnt1) begin
                rd_port      <= PORT1;
                last_gnt     <= PORT1;
                p1_last_addr <= bus.p1_addr;
            end
        end
    end

    // Route the memory's read data to the port that issued the read; the other port sees 0.
    assign bus.p0_rvalid = rd_pend && (rd_port == PORT0);
    assign bus.p1_rvalid = rd_pend && (rd_port == PORT1);
    assign bus.p0_rdata  = bus.p0_rvalid ? bus.mem_rd : '0;
    assign bus.p1_rdata  = bus.p1_rvalid ? bus.mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A small word-wide memory model sits on
// the memory side; every granted read pushes the expected port, data and due
// cycle into a scoreboard queue, and a monitor pops it when rvalid appears.
module tb_mem_arbiter;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    sb_entry_t exp_q[$];
    sb_entry_t mon_e;
    logic [31:0] mem_model [256];

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] seed(input int i);
        if (i == 64) return 32'hDEADBEEF;
        return 32'hA5000000 + 32'(i) * 32'h00010101;
    endfunction

    // Synchronous-read memory model; contents reload while reset is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= seed(i);
        end else begin
            bus.mem_rd <= mem_model[bus.mem_ra[9:2]];
            if (bus.mem_wen) mem_model[bus.mem_wa[9:2]] <= bus.mem_wd;
        end
    end

    // Scoreboard monitor: rvalid must match the oldest outstanding read, on time.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot", {63'd0, bus.p0_gnt & bus.p1_gnt}, 64'd0);
            check("rvalid_onehot", {63'd0, bus.p0_rvalid & bus.p1_rvalid}, 64'd0);
            if (bus.p0_rvalid || bus.p1_rvalid) begin
                check("rvalid_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rvalid_port", {63'd0, bus.p1_rvalid}, {63'd0, mon_e.port});
                    check("rvalid_latency", 64'(cyc), 64'(mon_e.due));
                    check("rdata", mon_e.port ? bus.p1_rdata : bus.p0_rdata, mon_e.data);
                    check("rdata_other_zero", mon_e.port ? bus.p0_rdata : bus.p1_rdata, 64'd0);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                check("rvalid_missing", {63'd0, bus.p0_rvalid | bus.p1_rvalid}, 64'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_funct3 = 3'b010;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_funct3 = 3'b010;
    endtask

    // One access on one port, expected to win immediately; leaves req asserted
    // and returns one cycle later (#1 after the next edge).
    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] exp_rd);
        sb_entry_t e;
        if (port) begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_funct3 = f3;
        end else begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_funct3 = f3;
        end
        @(negedge clk);
        check(port ? "p1_gnt" : "p0_gnt", {63'd0, port ? bus.p1_gnt : bus.p0_gnt}, 64'd1);
        check(port ? "p0_gnt_off" : "p1_gnt_off", {63'd0, port ? bus.p0_gnt : bus.p1_gnt}, 64'd0);
        check("mem_wen", {63'd0, bus.mem_wen}, {63'd0, we});
        check("mem_funct3", 64'(bus.mem_funct3), 64'(f3));
        if (we) begin
            check("mem_wa", bus.mem_wa, addr);
            check("mem_wd", bus.mem_wd, wdata);
        end else begin
            check("mem_ra", bus.mem_ra, addr);
            e.port = port; e.data = exp_rd; e.due = cyc + 1;
            exp_q.push_back(e);
        end
        step();
    endtask

    initial begin
        int mcnt;
        logic exp_w;
        sb_entry_t e;
        drive_idle();

        // Reset state, including requests presented while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_p0_gnt", {63'd0, bus.p0_gnt}, 64'd0);
        check("rst_p1_gnt", {63'd0, bus.p1_gnt}, 64'd0);
        check("rst_mem_wen", {63'd0, bus.mem_wen}, 64'd0);
        check("rst_p0_rvalid", {63'd0, bus.p0_rvalid}, 64'd0);
        check("rst_p1_rvalid", {63'd0, bus.p1_rvalid}, 64'd0);
        check("rst_mem_ra", bus.mem_ra, 64'd0);
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p1_req = 1'b1; bus.p1_we = 1'b1;
        #1;
        check("rst_req_p0_gnt", {63'd0, bus.p0_gnt}, 64'd0);
        check("rst_req_p1_gnt", {63'd0, bus.p1_gnt}, 64'd0);
        check("rst_req_mem_wen", {63'd0, bus.mem_wen}, 64'd0);
        drive_idle();
        step();
        rst = 1'b0;
        step();

        // Single read from port 0.
        access(1'b0, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF);
        bus.p0_req = 1'b0;
        @(negedge clk);
        check("single_p0_rvalid", {63'd0, bus.p0_rvalid}, 64'd1);
        check("single_p0_rdata", bus.p0_rdata, 64'hDEADBEEF);
        check("single_p1_rvalid", {63'd0, bus.p1_rvalid}, 64'd0);
        step();

        // Byte write from port 1; no rvalid may follow.
        access(1'b1, 1'b1, 32'h20, 32'h12345678, 3'b000, 32'h0);
        bus.p1_req = 1'b0; bus.p1_we = 1'b0;
        @(negedge clk);
        check("write_no_rvalid", {63'd0, bus.p0_rvalid | bus.p1_rvalid}, 64'd0);
        step();

        // Fairness: both ports request reads continuously.
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h200; bus.p0_funct3 = 3'b010;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h300; bus.p1_funct3 = 3'b010;
        mcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_w = (mcnt == MAX_BURST);
            check("fair_p1_gnt", {63'd0, bus.p1_gnt}, {63'd0, exp_w});
            check("fair_p0_gnt", {63'd0, bus.p0_gnt}, {63'd0, !exp_w});
            e.port = exp_w; e.data = exp_w ? seed(192) : seed(128); e.due = cyc + 1;
            exp_q.push_back(e);
            mcnt = exp_w ? 0 : mcnt + 1;
            step();
        end
        drive_idle();
        step();

        // Back-to-back cross-port reads.
        access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, seed(16));
        bus.p1_req = 1'b0;
        access(1'b0, 1'b0, 32'h44, 32'h0, 3'b010, seed(17));
        bus.p0_req = 1'b0;
        @(negedge clk);
        check("b2b_p0_rvalid", {63'd0, bus.p0_rvalid}, 64'd1);
        check("b2b_p1_quiet", {63'd0, bus.p1_rvalid}, 64'd0);
        step();

        // Idle after a read to 0x80: address parked, word funct3, no write.
        access(1'b0, 1'b0, 32'h80, 32'h0, 3'b011, seed(32));
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_mem_wen", {63'd0, bus.mem_wen}, 64'd0);
            check("idle_mem_funct3", 64'(bus.mem_funct3), 64'd2);
            check("idle_mem_ra", bus.mem_ra, 64'h80);
            check("idle_mem_wa", bus.mem_wa, 64'h80);
            check("idle_burst_cnt", 64'(dut.burst_cnt), 64'd0);
            step();
        end

        // Reset while a port-0 read is outstanding.
        access(1'b0, 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF);
        bus.p0_req = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_p0_rvalid", {63'd0, bus.p0_rvalid}, 64'd0);
        exp_q.delete();
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p1_req = 1'b1;
        @(negedge clk);
        check("midrst_p0_gnt", {63'd0, bus.p0_gnt}, 64'd0);
        check("midrst_p1_gnt", {63'd0, bus.p1_gnt}, 64'd0);
        check("midrst_mem_wen", {63'd0, bus.mem_wen}, 64'd0);
        drive_idle();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_p0_rvalid", {63'd0, bus.p0_rvalid}, 64'd0);
            check("postrst_p1_rvalid", {63'd0, bus.p1_rvalid}, 64'd0);
            step();
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
